instruction_encoder_loader: RTL and testbench
=============================================

# instruction_encoder_loader

Streaming RV32I instruction encoder and instruction-memory loader, the inverse of the decode-stage field extractor. Accepts per-instruction fields (opcode, rd, funct3, rs1, rs2, funct7, imm) plus a format tag over a valid/ready handshake. Packs each into a 32-bit instruction word and writes it to consecutive instruction-memory addresses. Used by the test/boot path to load programs into the pipeline's instruction memory.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin load session (sampled only in IDLE)
- base_addr  in  ADDR_W  first word address of the session
- count  in  ADDR_W+1  number of instructions in the session
- in_valid  in  1  field beat valid
- in_ready  out  1  block accepts a beat
- fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6–7 illegal
- opcode  in  7; rd  in  5; funct3  in  3; rs1  in  5; rs2  in  5; funct7  in  7  instruction fields
- imm  in  32  full immediate, byte offset, sign-extended
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  one-cycle end-of-session pulse
- err  out  1  sticky: illegal fmt or misaligned B/J immediate
- emitted  out  ADDR_W+1  words written this session

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 captures base_addr and count, clears err and emitted. Goes to RUN if count>0, else to DONE.
  - RUN: in_ready = 1. Each beat accepted with in_valid&&in_ready is encoded and decrements the remaining count. The beat that brings remaining to 0 moves the FSM to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Encoding, standard RV32I bit placement:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Fields unused by a format are ignored. Immediate bits above each format's range are silently dropped.
- Illegal fmt (6, 7): writes NOP 32'h0000_0013 and sets err.
- B/J with imm[0]=1: encodes anyway (bit 0 is not representable) and sets err.
- Address: mem_addr = base_addr + emitted, modulo 2^ADDR_W. Wrap-around is legal and silent.
- The memory side has no backpressure; every mem_we is accepted.

## Timing
- Reset values: FSM=IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, emitted = 0.
- start at cycle N (IDLE): busy=1 and in_ready=1 from N+1.
- Beat accepted at cycle N: mem_we/mem_addr/mem_wdata valid at N+1 (registered, 1-cycle latency). emitted increments at N+1.
- The final beat at cycle N gives DONE at N+1. The last mem_we and done coincide at N+1. busy=1 through that cycle, 0 at N+2.
- count=0: start at N gives done=1 at N+1 with no mem_we.
- in_valid low mid-session: no writes, state held, no timeout.
- in_ready is 0 in IDLE and DONE.
- err stays set until the next accepted start or rst.
- rst mid-session: all state cleared next cycle. A partially loaded image is abandoned with no done pulse.

## Structure
- Shared package:
  - fmt enum (FMT_R..FMT_J)
  - NOP_INSN constant
  - opcode constants (OP_REG=7'h33, OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F)
- Sub-module instruction_field_packer: purely combinational fields+fmt+imm to word, plus illegal/misaligned flags.
- Top holds the FSM, counters and output registers.

## Test plan
- R, add x3,x1,x2 (opcode 0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0), count=1, base 0: mem_wdata=0x002081B3 at addr 0, done same cycle.
- I/S, addi x5,x0,-1 then sw x2,8(x1) (f3=2), count=2, base 0x10: words 0xFFF00293 at 0x10, 0x0020A423 at 0x11, emitted=2.
- B, beq x0,x0,-4 (imm=0xFFFFFFFC, opcode 0x63): word 0xFE000EE3, err=0. Same with imm=0xFFFFFFFD: same word, err=1.
- Wrap, ADDR_W=10, base 0x3FE, count=3, in_valid toggled 1-0-1-0-1: writes at 0x3FE, 0x3FF, 0x000 only on accepted beats; busy low one cycle after done.
- Illegal fmt=6: writes 0x00000013 and err=1. Next start clears err. count=0 session gives done pulse one cycle after start, no mem_we.
- rst asserted mid-session after 1 of 4 beats: outputs return to reset values next cycle, no done. A new session then starts normally.

Source files
------------

// File: rtl/instruction_encoder_loader_pkg.sv
// ============================================================================
// Module      : instruction_encoder_loader_pkg
// Description : Shared formats, opcodes and constants for the RV32I encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_encoder_loader_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    localparam logic [6:0]  OP_REG    = 7'h33;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [6:0]  OP_JAL    = 7'h6F;

endpackage

`default_nettype wire

// File: rtl/instruction_encoder_loader_field_packer.sv
// ============================================================================
// Module      : instruction_field_packer
// Description : Combinational RV32I field packer with illegal/misaligned flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_field_packer
    import instruction_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    always_comb begin
        word_o       = NOP_INSN;
        illegal_o    = 1'b0;
        misaligned_o = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
                // bit 0 of a branch offset has no slot; flag but still encode
                misaligned_o = imm_i[0];
            end
            FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                          rd_i, opcode_i};
                misaligned_o = imm_i[0];
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instruction_encoder_loader.sv
// ============================================================================
// Module      : instruction_encoder_loader
// Description : Streams encoded RV32I words into consecutive imem addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder_loader
    import instruction_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   emitted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W:0]   emitted_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              err_q;

    logic [31:0] word;
    logic        illegal;
    logic        misaligned;
    logic        accept;
    logic        session_start;

    instruction_field_packer u_packer (
        .fmt_i        (fmt),
        .opcode_i     (opcode),
        .rd_i         (rd),
        .funct3_i     (funct3),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .funct7_i     (funct7),
        .imm_i        (imm),
        .word_o       (word),
        .illegal_o    (illegal),
        .misaligned_o (misaligned)
    );

    assign accept        = in_valid && (state_q == S_RUN);
    assign session_start = start && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (count == '0) ? S_DONE : S_RUN;
            S_RUN:  if (accept && remaining_q == (ADDR_W+1)'(1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            remaining_q <= '0;
            emitted_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= accept;
            if (session_start) begin
                base_q      <= base_addr;
                remaining_q <= count;
                emitted_q   <= '0;
                err_q       <= 1'b0;
            end else if (accept) begin
                // address wraps naturally in the ADDR_W-bit adder
                mem_addr_q  <= base_q + emitted_q[ADDR_W-1:0];
                mem_wdata_q <= word;
                remaining_q <= remaining_q - (ADDR_W+1)'(1);
                emitted_q   <= emitted_q + (ADDR_W+1)'(1);
                if (illegal || misaligned) err_q <= 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign emitted   = emitted_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder_loader.sv
// ============================================================================
// Module      : tb_instruction_encoder_loader
// Description : Scoreboard bench for the RV32I encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_encoder_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0;
    logic [2:0]        funct3 = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   emitted;

    instruction_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .emitted(emitted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        logic [ADDR_W+31:0] e;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {22'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {22'd0, mem_addr}, {22'd0, e[ADDR_W+31:32]});
                    check("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    task automatic start_session(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        @(negedge clk);
        start = 1'b1; base_addr = b; count = c;
        exp_addr = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("err_cleared_on_start", {31'd0, err}, 32'd0);
        if (c == '0) begin
            check("done_count0", {31'd0, done}, 32'd1);
            check("ready_count0", {31'd0, in_ready}, 32'd0);
        end else begin
            check("ready_after_start", {31'd0, in_ready}, 32'd1);
        end
    endtask

    // Called at a negedge: presents one beat for exactly one cycle.
    task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [6:0] f7, input logic [31:0] im, input logic [31:0] w,
                        input bit last);
        check("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
        fmt = f; opcode = op; rd = rdv; funct3 = f3; rs1 = r1; rs2 = r2;
        funct7 = f7; imm = im; in_valid = 1'b1;
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (last) begin
            check("done_with_last_write", {31'd0, done}, 32'd1);
            check("ready_low_in_done", {31'd0, in_ready}, 32'd0);
        end else begin
            check("no_early_done", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic end_session();
        @(negedge clk);
        check("busy_low_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        exp_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_emitted", {21'd0, emitted}, 32'd0);

        // add x3,x1,x2
        start_session(10'h000, 11'd1);
        beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b1);
        check("emitted_add", {21'd0, emitted}, 32'd1);
        end_session();

        // addi x5,x0,-1 ; sw x2,8(x1)
        start_session(10'h010, 11'd2);
        beat(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd31, 7'h7F, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
        beat(3'd2, 7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'h7F, 32'h0000_0008, 32'h0020A423, 1'b1);
        check("emitted_is", {21'd0, emitted}, 32'd2);
        end_session();

        // beq -4 aligned, then misaligned
        start_session(10'h020, 11'd1);
        beat(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b1);
        check("err_beq_aligned", {31'd0, err}, 32'd0);
        end_session();
        start_session(10'h020, 11'd1);
        beat(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFD, 32'hFE000EE3, 1'b1);
        check("err_beq_misaligned", {31'd0, err}, 32'd1);
        end_session();

        // lui x1,0x12345 ; jal x1,8
        start_session(10'h030, 11'd2);
        beat(3'd4, 7'h37, 5'd1, 3'd7, 5'd9, 5'd9, 7'd9, 32'h1234_5FFF, 32'h123450B7, 1'b0);
        beat(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0008, 32'h008000EF, 1'b1);
        check("err_uj", {31'd0, err}, 32'd0);
        end_session();

        // wrap with gaps on in_valid
        start_session(10'h3FE, 11'd3);
        beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b0);
        @(negedge clk);
        check("held_emitted", {21'd0, emitted}, 32'd1);
        beat(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
        @(negedge clk);
        beat(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'h0000_0008, 32'h0020A423, 1'b1);
        check("emitted_wrap", {21'd0, emitted}, 32'd3);
        end_session();

        // illegal format
        start_session(10'h040, 11'd1);
        beat(3'd6, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 32'h00000013, 1'b1);
        check("err_illegal", {31'd0, err}, 32'd1);
        end_session();
        check("err_sticky", {31'd0, err}, 32'd1);

        // count=0 session clears err, pulses done, writes nothing
        start_session(10'h050, 11'd0);
        end_session();

        // reset mid-session after 1 of 4 beats
        start_session(10'h060, 11'd4);
        beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b0);
        in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_emitted", {21'd0, emitted}, 32'd0);
        check("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end

        // fresh session after reset
        start_session(10'h005, 11'd1);
        beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b1);
        end_session();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
